// File: rtl/reg_pipe_pkg.sv
// reg_pipe_pkg: shared helpers for the elastic register pipeline.
// Optional feature macro: REG_PIPE_OCC_EN (occupancy counter port on reg_pipe).
// A stage is a valid bit plus WIDTH bits of payload. The struct needs a width,
// so it is a macro that each user expands with its own WIDTH.
`ifndef REG_PIPE_STAGE_T
`define REG_PIPE_STAGE_T(W) struct packed { logic v; logic [(W)-1:0] d; }
`endif

package reg_pipe_pkg;

   // Width of a counter that must hold 0..depth inclusive.
   function automatic int occ_w(input int depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/reg_pipe_if.sv
// reg_pipe_if: valid/ready stream on both sides of the pipeline.
// The master side feeds words in and accepts words out; the slave is the pipe.
interface reg_pipe_if
   import reg_pipe_pkg::*;
#(
   parameter int WIDTH = 8
);
   logic             in_valid;
   logic [WIDTH-1:0] in_data;
   logic             in_ready;
   logic             out_valid;
   logic [WIDTH-1:0] out_data;
   logic             out_ready;

   modport master (output in_valid, in_data, out_ready,
                   input  in_ready, out_valid, out_data);
   modport slave  (input  in_valid, in_data, out_ready,
                   output in_ready, out_valid, out_data);
endinterface

// File: rtl/reg_pipe_stage.sv
// reg_pipe_stage: one pipeline register (valid + payload) with its local ready.
// Ready is combinational so a full pipe still moves one word per cycle.
module reg_pipe_stage
   import reg_pipe_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             flush,
   input  logic             src_v,
   input  logic [WIDTH-1:0] src_d,
   input  logic             rdy_nxt,
   output logic             rdy,
   output logic             v,
   output logic [WIDTH-1:0] d
);
   typedef `REG_PIPE_STAGE_T(WIDTH) stage_t;

   stage_t q;

   // An empty stage always takes from upstream; a full one only if it can drain.
   assign rdy = !q.v | rdy_nxt;
   assign v   = q.v;
   assign d   = q.d;

   // Load when there is room, drop valid on flush (payload kept), freeze when !en.
   always_ff @(posedge clk) begin
      if (rst) begin
         q <= '0;
      end else if (en) begin
         if (flush)
            q.v <= 1'b0;
         else if (rdy)
            q <= stage_t'({src_v, src_d});
      end
   end
endmodule

// File: rtl/reg_pipe.sv
// reg_pipe: DEPTH-stage elastic register pipeline with global enable and flush.
// Optional feature macro: REG_PIPE_OCC_EN adds the registered occupancy port occ.
module reg_pipe
   import reg_pipe_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DEPTH = 3
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      en,
   input  logic                      flush,
   reg_pipe_if.slave                 bus
`ifdef REG_PIPE_OCC_EN
   ,
   output logic [occ_w(DEPTH)-1:0]   occ
`endif
);
   if (DEPTH < 1) begin : g_bad_depth
      $error("reg_pipe: DEPTH must be >= 1");
   end
   if (WIDTH < 1) begin : g_bad_width
      $error("reg_pipe: WIDTH must be >= 1");
   end

   // Stage 0 faces the input; each stage's ready looks at the one after it.
   // Per-stage nets (not one vector) keep the ready chain free of false loops.
   for (genvar i = 0; i < DEPTH; i++) begin : g_st
      logic             rdy, rdy_nxt, src_v, v;
      logic [WIDTH-1:0] src_d, d;

      if (i == DEPTH - 1) begin : g_tail
         assign rdy_nxt = bus.out_ready;
      end else begin : g_link
         assign rdy_nxt = g_st[i+1].rdy;
      end

      if (i == 0) begin : g_head
         assign src_v = bus.in_valid;
         assign src_d = bus.in_data;
      end else begin : g_body
         assign src_v = g_st[i-1].v;
         assign src_d = g_st[i-1].d;
      end

      reg_pipe_stage #(.WIDTH(WIDTH)) u_stage (
         .clk     (clk),
         .rst     (rst),
         .en      (en),
         .flush   (flush),
         .src_v   (src_v),
         .src_d   (src_d),
         .rdy_nxt (rdy_nxt),
         .rdy     (rdy),
         .v       (v),
         .d       (d)
      );
   end

   // No entry while frozen or flushing; output hidden while frozen, data ungated.
   assign bus.in_ready  = en & ~flush & g_st[0].rdy;
   assign bus.out_valid = en & g_st[DEPTH-1].v;
   assign bus.out_data  = g_st[DEPTH-1].d;

`ifdef REG_PIPE_OCC_EN
   localparam int OW = occ_w(DEPTH);

   logic in_xfer, out_xfer;
   assign in_xfer  = bus.in_valid  & bus.in_ready;
   assign out_xfer = bus.out_valid & bus.out_ready;

   // Track valid-stage count from the two handshakes; flush empties the pipe.
   always_ff @(posedge clk) begin
      if (rst || (en && flush))
         occ <= '0;
      else if (in_xfer && !out_xfer)
         occ <= occ + OW'(1);
      else if (!in_xfer && out_xfer)
         occ <= occ - OW'(1);
   end
`endif
endmodule

// File: tb/tb_reg_pipe.sv
// tb_reg_pipe: directed test of reg_pipe (WIDTH=8, DEPTH=3) with a word scoreboard.
// Words are queued when accepted and popped/compared when the pipe emits them.
module tb_reg_pipe;
   import reg_pipe_pkg::*;

   localparam int WIDTH = 8;
   localparam int DEPTH = 3;

   logic clk = 1'b0;
   logic rst, en, flush;

   reg_pipe_if #(.WIDTH(WIDTH)) bus();

`ifdef REG_PIPE_OCC_EN
   logic [occ_w(DEPTH)-1:0] occ;
`endif

   reg_pipe #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .clk   (clk),
      .rst   (rst),
      .en    (en),
      .flush (flush),
      .bus   (bus)
`ifdef REG_PIPE_OCC_EN
      ,
      .occ   (occ)
`endif
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;
   logic [WIDTH-1:0] sb [$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_occ(input string tag, input int exp);
`ifdef REG_PIPE_OCC_EN
      chk(tag, 32'(occ), exp);
`endif
   endtask

   // Sample this cycle's handshakes before the edge, then advance one clock.
   task automatic tick();
      logic [WIDTH-1:0] exp;
      #1;
      if (rst) begin
         sb.delete();
      end else begin
         if (bus.out_valid && bus.out_ready) begin
            chk("out_expected", 32'(sb.size() != 0), 1);
            if (sb.size() != 0) begin
               exp = sb.pop_front();
               chk("out_data", 32'(bus.out_data), 32'(exp));
            end
         end
         if (en && flush)
            sb.delete();
         else if (bus.in_valid && bus.in_ready)
            sb.push_back(bus.in_data);
      end
      @(posedge clk);
      #1;
      chk_occ("occ_track", sb.size());
   endtask

   initial begin
      // 1. reset with input offered
      rst = 1'b1; en = 1'b1; flush = 1'b0;
      bus.in_valid = 1'b1; bus.in_data = 8'hA6; bus.out_ready = 1'b1;
      tick(); tick();
      chk("rst_out_valid", 32'(bus.out_valid), 0);
      chk("rst_out_data", 32'(bus.out_data), 0);
      chk_occ("rst_occ", 0);
      rst = 1'b0; bus.in_valid = 1'b0;
      #1;
      chk("rst_in_ready", 32'(bus.in_ready), 1);

      // 2. streaming, latency DEPTH edges
      bus.in_valid = 1'b1;
      bus.in_data = 8'hA6; tick(); chk("lat_e1", 32'(bus.out_valid), 0);
      bus.in_data = 8'h3C; tick(); chk("lat_e2", 32'(bus.out_valid), 0);
      bus.in_data = 8'h5A; tick(); chk("lat_e3", 32'(bus.out_valid), 1);
      chk("lat_data", 32'(bus.out_data), 32'h A6);
      bus.in_valid = 1'b0;
      tick(); tick(); tick();
      chk("s2_drained_valid", 32'(bus.out_valid), 0);
      chk("s2_sb_empty", 32'(sb.size()), 0);

      // 3. backpressure, push and pop together when full
      bus.out_ready = 1'b0; bus.in_valid = 1'b1;
      bus.in_data = 8'h11; tick();
      bus.in_data = 8'h22; tick();
      bus.in_data = 8'h33; tick();
      bus.in_data = 8'h44;
      #1;
      chk("full_in_ready", 32'(bus.in_ready), 0);
      chk_occ("full_occ", 3);
      tick();
      chk("full_hold_data", 32'(bus.out_data), 32'h11);
      bus.out_ready = 1'b1;
      #1;
      chk("full_pass_in_ready", 32'(bus.in_ready), 1);
      tick();
      bus.in_valid = 1'b0;
      tick(); tick(); tick();
      chk("s3_drained_valid", 32'(bus.out_valid), 0);
      chk("s3_sb_empty", 32'(sb.size()), 0);

      // 4. global enable freeze mid-stream
      bus.in_valid = 1'b1;
      for (int k = 1; k <= 3; k++) begin
         bus.in_data = 8'(8'h80 + k);
         tick();
      end
      chk("s4_pre_valid", 32'(bus.out_valid), 1);
      en = 1'b0; bus.in_data = 8'h84;
      #1;
      chk("frz_in_ready", 32'(bus.in_ready), 0);
      chk("frz_out_valid", 32'(bus.out_valid), 0);
      for (int k = 0; k < 4; k++) begin
         tick();
         chk("frz_in_ready_c", 32'(bus.in_ready), 0);
         chk("frz_out_valid_c", 32'(bus.out_valid), 0);
         chk("frz_out_data", 32'(bus.out_data), 32'h81);
         chk_occ("frz_occ", 3);
      end
      en = 1'b1;
      for (int k = 4; k <= 6; k++) begin
         bus.in_data = 8'(8'h80 + k);
         tick();
      end
      bus.in_valid = 1'b0;
      tick(); tick(); tick();
      chk("s4_drained_valid", 32'(bus.out_valid), 0);
      chk("s4_sb_empty", 32'(sb.size()), 0);

      // 5. flush with a word offered
      bus.out_ready = 1'b0; bus.in_valid = 1'b1;
      bus.in_data = 8'h91; tick();
      bus.in_data = 8'h92; tick();
      bus.in_data = 8'h77; flush = 1'b1;
      #1;
      chk("flush_in_ready", 32'(bus.in_ready), 0);
      tick();
      flush = 1'b0; bus.in_valid = 1'b0;
      #1;
      chk("flush_out_valid", 32'(bus.out_valid), 0);
      chk_occ("flush_occ", 0);
      bus.out_ready = 1'b1;
      tick(); tick(); tick(); tick();
      chk("flush_quiet", 32'(bus.out_valid), 0);

      // 6. reset with words in flight
      bus.out_ready = 1'b0; bus.in_valid = 1'b1;
      bus.in_data = 8'hC1; tick();
      bus.in_data = 8'hC2; tick();
      bus.in_data = 8'hC3; tick();
      bus.in_valid = 1'b0; rst = 1'b1;
      tick();
      chk("rst2_out_valid", 32'(bus.out_valid), 0);
      chk("rst2_out_data", 32'(bus.out_data), 0);
      chk_occ("rst2_occ", 0);
      rst = 1'b0; bus.out_ready = 1'b1; bus.in_valid = 1'b1;
      bus.in_data = 8'hD1; tick();
      bus.in_data = 8'hD2; tick();
      bus.in_valid = 1'b0;
      tick(); tick(); tick(); tick();
      chk("s6_drained_valid", 32'(bus.out_valid), 0);
      chk("s6_sb_empty", 32'(sb.size()), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
